// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter
// Shares the single combinational read port of the program-memory ROM between
// instruction fetch (F) and the debug/loader readback port (D). Each request
// carries a byte address in the text segment. The block translates that address
// to a word index and range-checks it. A granted request returns its data one
// cycle later from a registered response, and a new grant can be made every cycle.
//
// Configuration macro: PM_ARB_FIXED_PRIORITY_EN
//   undefined (default): round-robin between F and D on conflict.
//   defined            : F always wins conflicts, so D can be starved.
//                        Ports and latency are identical in both builds.

`default_nettype none

module program_memory_arbiter #(
   parameter int                    MEMORY_DEPTH = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   // requester F: instruction fetch
   input  logic                  fetch_req_i,
   input  logic [DATA_WIDTH-1:0] fetch_addr_i,
   output logic                  fetch_gnt_o,
   output logic                  fetch_valid_o,
   output logic [DATA_WIDTH-1:0] fetch_data_o,
   output logic                  fetch_err_o,
   // requester D: debug / loader readback
   input  logic                  dbg_req_i,
   input  logic [DATA_WIDTH-1:0] dbg_addr_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_valid_o,
   output logic [DATA_WIDTH-1:0] dbg_data_o,
   output logic                  dbg_err_o,
   // program memory read port
   output logic [DATA_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i
);

   localparam logic [DATA_WIDTH-1:0] DEPTH_C = DATA_WIDTH'(MEMORY_DEPTH);
   localparam logic [DATA_WIDTH-1:0] ZERO_C  = {DATA_WIDTH{1'b0}};

   // Address is faulty if misaligned, below the text base, or past the last ROM word.
   function automatic logic addr_fault(input logic [DATA_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2'd2) >= DEPTH_C);
   endfunction

   // Byte address to ROM word index, relative to the text base.
   function automatic logic [DATA_WIDTH-1:0] word_index(input logic [DATA_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return off >> 2'd2;
   endfunction

   logic                  fetch_gnt_s;
   logic                  dbg_gnt_s;
   logic [DATA_WIDTH-1:0] sel_addr_s;
   logic                  any_gnt_s;
   logic                  fault_s;
   logic [DATA_WIDTH-1:0] rom_addr_s;

   logic                  fetch_valid_r;
   logic                  fetch_err_r;
   logic [DATA_WIDTH-1:0] fetch_data_r;
   logic                  dbg_valid_r;
   logic                  dbg_err_r;
   logic [DATA_WIDTH-1:0] dbg_data_r;

`ifndef PM_ARB_FIXED_PRIORITY_EN
   typedef enum logic {
      WIN_F = 1'b0,
      WIN_D = 1'b1
   } winner_t;

   winner_t last_winner_r;
`endif

   // Arbitration: pick at most one requester this cycle; nothing while in reset.
   always_comb begin
      fetch_gnt_s = 1'b0;
      dbg_gnt_s   = 1'b0;
      if (reset) begin
         fetch_gnt_s = 1'b0;
         dbg_gnt_s   = 1'b0;
      end else begin
`ifdef PM_ARB_FIXED_PRIORITY_EN
         fetch_gnt_s = fetch_req_i;
         dbg_gnt_s   = dbg_req_i & ~fetch_req_i;
`else
         case ({fetch_req_i, dbg_req_i})
            2'b10:   fetch_gnt_s = 1'b1;
            2'b01:   dbg_gnt_s   = 1'b1;
            2'b11: begin
               if (last_winner_r == WIN_D) begin
                  fetch_gnt_s = 1'b1;
               end else begin
                  dbg_gnt_s   = 1'b1;
               end
            end
            default: begin
               fetch_gnt_s = 1'b0;
               dbg_gnt_s   = 1'b0;
            end
         endcase
`endif
      end
   end

   // Translate the winner's address; an idle or faulting cycle drives index 0 to the ROM.
   always_comb begin
      any_gnt_s  = fetch_gnt_s | dbg_gnt_s;
      sel_addr_s = ZERO_C;
      if (fetch_gnt_s) begin
         sel_addr_s = fetch_addr_i;
      end else if (dbg_gnt_s) begin
         sel_addr_s = dbg_addr_i;
      end else begin
         sel_addr_s = ZERO_C;
      end
      fault_s = any_gnt_s & addr_fault(sel_addr_s);
      if (any_gnt_s && !fault_s) begin
         rom_addr_s = word_index(sel_addr_s);
      end else begin
         rom_addr_s = ZERO_C;
      end
   end

`ifndef PM_ARB_FIXED_PRIORITY_EN
   // Remember who won last so the other side wins the next conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner_r <= WIN_D;
      end else if (fetch_gnt_s) begin
         last_winner_r <= WIN_F;
      end else if (dbg_gnt_s) begin
         last_winner_r <= WIN_D;
      end else begin
         last_winner_r <= last_winner_r;
      end
   end
`endif

   // Response registers: one-cycle read latency; data holds while no new response.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid_r <= 1'b0;
         fetch_err_r   <= 1'b0;
         fetch_data_r  <= ZERO_C;
         dbg_valid_r   <= 1'b0;
         dbg_err_r     <= 1'b0;
         dbg_data_r    <= ZERO_C;
      end else begin
         fetch_valid_r <= fetch_gnt_s;
         fetch_err_r   <= fetch_gnt_s & fault_s;
         dbg_valid_r   <= dbg_gnt_s;
         dbg_err_r     <= dbg_gnt_s & fault_s;
         if (fetch_gnt_s) begin
            fetch_data_r <= fault_s ? ZERO_C : rom_data_i;
         end else begin
            fetch_data_r <= fetch_data_r;
         end
         if (dbg_gnt_s) begin
            dbg_data_r <= fault_s ? ZERO_C : rom_data_i;
         end else begin
            dbg_data_r <= dbg_data_r;
         end
      end
   end

   assign fetch_gnt_o   = fetch_gnt_s;
   assign dbg_gnt_o     = dbg_gnt_s;
   assign rom_addr_o    = rom_addr_s;
   assign fetch_valid_o = fetch_valid_r;
   assign fetch_err_o   = fetch_err_r;
   assign fetch_data_o  = fetch_data_r;
   assign dbg_valid_o   = dbg_valid_r;
   assign dbg_err_o     = dbg_err_r;
   assign dbg_data_o    = dbg_data_r;

endmodule

`default_nettype wire

// File: tb/tb_program_memory_arbiter.sv
// Testbench for program_memory_arbiter: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the arbiter.
// Honours PM_ARB_FIXED_PRIORITY_EN the same way the design does.

`timescale 1ns/1ps

module tb_program_memory_arbiter;

   localparam int          DEPTH = 32;
   localparam int          DW    = 32;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic          clk;
   logic          reset;
   logic          fetch_req_i;
   logic [DW-1:0] fetch_addr_i;
   logic          fetch_gnt_o;
   logic          fetch_valid_o;
   logic [DW-1:0] fetch_data_o;
   logic          fetch_err_o;
   logic          dbg_req_i;
   logic [DW-1:0] dbg_addr_i;
   logic          dbg_gnt_o;
   logic          dbg_valid_o;
   logic [DW-1:0] dbg_data_o;
   logic          dbg_err_o;
   logic [DW-1:0] rom_addr_o;
   logic [DW-1:0] rom_data_i;

   logic [31:0] rom [DEPTH];

   int checks;
   int failures;

   // model state
   logic        m_last_d;
   logic        m_fv, m_fe, m_dv, m_de;
   logic [31:0] m_fd, m_dd;
   int          n_fgnt, n_dgnt;

   program_memory_arbiter #(
      .MEMORY_DEPTH(DEPTH),
      .DATA_WIDTH  (DW),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req_i  (fetch_req_i),
      .fetch_addr_i (fetch_addr_i),
      .fetch_gnt_o  (fetch_gnt_o),
      .fetch_valid_o(fetch_valid_o),
      .fetch_data_o (fetch_data_o),
      .fetch_err_o  (fetch_err_o),
      .dbg_req_i    (dbg_req_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_gnt_o    (dbg_gnt_o),
      .dbg_valid_o  (dbg_valid_o),
      .dbg_data_o   (dbg_data_o),
      .dbg_err_o    (dbg_err_o),
      .rom_addr_o   (rom_addr_o),
      .rom_data_i   (rom_data_i)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational ROM model; out-of-range index returns a poison pattern
   assign rom_data_i = (rom_addr_o < 32'(DEPTH)) ? rom[rom_addr_o[4:0]] : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // spec rule: misaligned, below base, or word index beyond the ROM
   function automatic logic ref_fault(input logic [31:0] a);
      longint ua;
      ua = longint'(a);
      return (ua % 4 != 0) || (ua < longint'(BASE)) || ((ua - longint'(BASE)) / 4 >= DEPTH);
   endfunction

   // One clock cycle. rmode: 0 = normal, 1 = reset high for the whole cycle,
   // 2 = reset rises after the grant has been observed, sampled at the next edge.
   task automatic step(input logic fr, input logic [31:0] fa,
                       input logic dr, input logic [31:0] da, input int rmode);
      logic        eg_f, eg_d, ef;
      logic [31:0] a, ea;
      reset        = (rmode == 1);
      fetch_req_i  = fr;
      fetch_addr_i = fa;
      dbg_req_i    = dr;
      dbg_addr_i   = da;
      #1;
      eg_f = 1'b0;
      eg_d = 1'b0;
      if (rmode != 1) begin
`ifdef PM_ARB_FIXED_PRIORITY_EN
         eg_f = fr;
         eg_d = dr && !fr;
`else
         if (fr && dr) begin
            eg_f = m_last_d;
            eg_d = !m_last_d;
         end else begin
            eg_f = fr;
            eg_d = dr;
         end
`endif
      end
      a  = eg_f ? fa : (eg_d ? da : 32'h0);
      ef = (eg_f || eg_d) && ref_fault(a);
      ea = ((eg_f || eg_d) && !ef) ? 32'((longint'(a) - longint'(BASE)) / 4) : 32'h0;
      chk("fetch_gnt", {31'b0, fetch_gnt_o}, {31'b0, eg_f});
      chk("dbg_gnt",   {31'b0, dbg_gnt_o},   {31'b0, eg_d});
      chk("rom_addr",  rom_addr_o, ea);
      if (eg_f) n_fgnt++;
      if (eg_d) n_dgnt++;
      if (rmode == 2) reset = 1'b1;
      @(posedge clk);
      #1;
      if (rmode != 0) begin
         m_fv = 1'b0; m_fe = 1'b0; m_fd = 32'h0;
         m_dv = 1'b0; m_de = 1'b0; m_dd = 32'h0;
         m_last_d = 1'b1;
      end else begin
         m_fv = eg_f;
         m_fe = eg_f && ef;
         m_dv = eg_d;
         m_de = eg_d && ef;
         if (eg_f) m_fd = ef ? 32'h0 : rom[ea];
         if (eg_d) m_dd = ef ? 32'h0 : rom[ea];
         if (eg_f) m_last_d = 1'b0;
         else if (eg_d) m_last_d = 1'b1;
      end
      chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, m_fv});
      chk("fetch_err",   {31'b0, fetch_err_o},   {31'b0, m_fe});
      chk("fetch_data",  fetch_data_o, m_fd);
      chk("dbg_valid",   {31'b0, dbg_valid_o},   {31'b0, m_dv});
      chk("dbg_err",     {31'b0, dbg_err_o},     {31'b0, m_de});
      chk("dbg_data",    dbg_data_o, m_dd);
   endtask

   function automatic logic [31:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) return BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (sel == 6) return BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (sel == 7) return BASE - 32'd4 * 32'($urandom_range(1, 8));
      else if (sel == 8) return BASE + 32'd4 * 32'($urandom_range(DEPTH, DEPTH + 8));
      else return $urandom;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      n_fgnt   = 0;
      n_dgnt   = 0;
      m_last_d = 1'b1;
      m_fv = 1'b0; m_fe = 1'b0; m_fd = 32'h0;
      m_dv = 1'b0; m_de = 1'b0; m_dd = 32'h0;
      for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0203;

      reset        = 1'b1;
      fetch_req_i  = 1'b0;
      fetch_addr_i = 32'h0;
      dbg_req_i    = 1'b0;
      dbg_addr_i   = 32'h0;
      @(posedge clk);
      #1;

      // reset state
      step(1'b0, 32'h0, 1'b0, 32'h0, 1);
      step(1'b1, 32'h0040_0000, 1'b1, 32'h0040_0004, 1);

      // single F request, word 2
      step(1'b1, 32'h0040_0008, 1'b0, 32'h0, 0);
      chk("single_f_data", fetch_data_o, rom[2]);
      step(1'b0, 32'h0, 1'b0, 32'h0, 0);

      // re-arm reset so the conflict starts from a fresh last_winner
      step(1'b0, 32'h0, 1'b0, 32'h0, 1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0040_0000, 1'b1, 32'h0040_0004, 0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 0);

      // D faults: misaligned, below base, one past the end
      step(1'b0, 32'h0, 1'b1, 32'h0040_0002, 0);
      step(1'b0, 32'h0, 1'b1, 32'h003F_FFFC, 0);
      step(1'b0, 32'h0, 1'b1, 32'h0040_0080, 0);
      chk("fault_dbg_err", {31'b0, dbg_err_o}, 32'h1);

      // last ROM word
      step(1'b1, 32'h0040_007C, 1'b0, 32'h0, 0);
      chk("boundary_data", fetch_data_o, rom[31]);

      // reset arriving after a grant discards the pending response
      step(1'b1, 32'h0040_0010, 1'b0, 32'h0, 2);
      step(1'b1, 32'h0040_0014, 1'b1, 32'h0040_0018, 0);
      chk("post_reset_f_first", fetch_data_o, rom[5]);
      step(1'b0, 32'h0, 1'b0, 32'h0, 0);

`ifdef PM_ARB_FIXED_PRIORITY_EN
      // fixed priority: D starves while F keeps requesting
      n_fgnt = 0;
      n_dgnt = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0024, 0);
      chk("fixed_f_grants", 32'(n_fgnt), 32'd5);
      chk("fixed_d_grants", 32'(n_dgnt), 32'd0);
      step(1'b0, 32'h0, 1'b1, 32'h0040_0024, 0);
      chk("fixed_d_after_f_drop", dbg_data_o, rom[9]);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), rand_addr(),
              1'($urandom_range(0, 1)), rand_addr(),
              ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, 2)) : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
- Shares the single combinational read port of the program memory ROM between two requesters.
- Requester F is instruction fetch; requester D is the debug/loader readback port.
- Translates byte addresses in the text segment into word indices and checks the range.
- Round-robin arbitration, valid/ready-style request/grant, registered read data with 1-cycle latency and back-to-back throughput.

Parameters:
- MEMORY_DEPTH, 32: number of ROM words; must match the program memory instance.
- DATA_WIDTH, 32: address and data width.
- BASE_ADDR, 32'h0040_0000: byte address of ROM word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req_i  input  1  F request; held with address until granted.
- fetch_addr_i  input  DATA_WIDTH  F byte address.
- fetch_gnt_o  output  1  F request accepted this cycle (combinational).
- fetch_valid_o  output  1  F response valid (registered).
- fetch_data_o  output  DATA_WIDTH  F instruction word.
- fetch_err_o  output  1  F address fault, qualified by fetch_valid_o.
- dbg_req_i, dbg_addr_i, dbg_gnt_o, dbg_valid_o, dbg_data_o, dbg_err_o: same as the F ports, for requester D.
- rom_addr_o  output  DATA_WIDTH  word index to the program memory Address_i.
- rom_data_i  input  DATA_WIDTH  Instruction_o from the program memory.

Behaviour:
- Reset:
  - All *_valid_o, *_err_o and *_data_o are 0.
  - last_winner is D, so F wins the first conflict.
  - Grants are forced to 0 while reset is high.
- Arbitration (combinational each cycle):
  - Only one requester active: it is granted.
  - Both active: the one that is not last_winner is granted.
  - Neither active: no grant, and rom_addr_o = 0.
  - At most one gnt is high per cycle.
- last_winner updates at the clock edge on any grant.
- Translation for the selected address A:
  - off = A - BASE_ADDR, computed at DATA_WIDTH bits.
  - Fault if A[1:0] != 0, if A < BASE_ADDR, or if off[DATA_WIDTH-1:2] >= MEMORY_DEPTH.
  - No fault: rom_addr_o = off >> 2.
  - Fault: rom_addr_o = 0.
- Response for a grant in cycle N, at edge N+1:
  - The winner's valid_o goes to 1 and its data_o takes rom_data_i, or 0 on a fault.
  - The winner's err_o takes the fault flag.
  - The other requester's valid_o and err_o go to 0.
- No grant in cycle N: both valid_o are 0 in N+1.
- data_o holds its last value when valid_o is 0.
- Throughput: one grant per cycle, back-to-back; a requester may reassert in the cycle after its grant.
- Requester rule: an ungranted requester must hold req and addr stable. Changing them before grant is legal but the old request is dropped; the block has no request storage.
- Reset mid-operation: a response pending from the cycle before reset is discarded, and valid_o = 0 on the edge where reset is sampled high.
- There are no other state machines. State is last_winner plus the two response registers.

Optional Feature:
- Macro: PM_ARB_FIXED_PRIORITY_EN.
- Defined: F always wins conflicts, last_winner is unused, and D can be starved.
- Not defined: round-robin as described above.
- Defining the macro changes no ports or latency.

Test Plan:
- Reset, then single F request: fetch_addr_i=0x0040_0008 held for 1 cycle -> fetch_gnt_o=1 and rom_addr_o=2 in that cycle; next cycle fetch_valid_o=1, fetch_data_o=rom[2], fetch_err_o=0, dbg_valid_o=0.
- Conflict after reset: both request (F 0x0040_0000, D 0x0040_0004) continuously for 4 cycles -> grants F,D,F,D; valid responses rom[0],rom[1],rom[0],rom[1] alternating between ports, each 1 cycle after its grant.
- Faults: D requests 0x0040_0002 (misaligned), 0x003F_FFFC (below base), and 0x0040_0080 (index 32 >= 32) -> each granted; next cycle dbg_valid_o=1, dbg_err_o=1, dbg_data_o=0, and rom_addr_o=0 during the grant cycle.
- Boundary: F requests 0x0040_007C -> rom_addr_o=31, no error.
- Reset mid-flight: F granted in cycle N, reset=1 sampled at edge N+1 -> fetch_valid_o=0 after that edge. After release, a simultaneous F and D request grants F first.
- With PM_ARB_FIXED_PRIORITY_EN defined: both requesting for 5 cycles -> fetch_gnt_o=1 all 5 cycles, dbg_gnt_o=0. When F drops, D is granted in the same cycle.
